// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexes NDIG hex digits onto one shared seven-segment decoder.
// Each digit is shown for DWELL cycles followed by GAP_CYC blanked cycles so
// the anode switch never overlaps lit segments (no ghosting). New values are
// staged and only become visible at frame start, so a frame never mixes two
// values. Leading zero digits can be blanked; digit 0 is always shown.
module seven_seg_scan_ctrl #(
  parameter int NDIG        = 4,
  parameter int DWELL       = 4,
  parameter int GAP_CYC     = 1,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [4*NDIG-1:0] Value,
  input  logic              Load,
  input  logic              Blank,
  output logic [3:0]        Digit,
  output logic              EnableSegs,
  output logic [NDIG-1:0]   AnodeEn,
  output logic              LoadAck
);

  localparam int CNT_MAX = (DWELL > GAP_CYC) ? DWELL : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NDIG);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_nx;
  logic [4*NDIG-1:0] staging;
  logic [4*NDIG-1:0] shadow;
  logic [4*NDIG-1:0] shadow_nx;
  logic              pending;
  logic              frame_start;
  logic              commit;
  logic              upper_zero;
  logic              lz;
  logic [3:0]        digit_sel;
  logic [3:0]        digit_nx;
  logic              en_nx;
  logic [NDIG-1:0]   anode_nx;

  // Next-state logic: dwell/gap timing and digit index advance.
  always_comb begin
    // NOTE: every signal driven here gets a default first; any path that
    // left one unassigned would infer a latch.
    state_nx    = state;
    cnt_nx      = cnt + CW'(1);
    idx_nx      = idx;
    frame_start = 1'b0;
    case (state)
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx    = SHOW;
          cnt_nx      = '0;
          // Explicit compare so NDIG need not be a power of two.
          idx_nx      = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          frame_start = (idx == IDX_LAST);
        end
      end
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  // Frame-start commit; a Load on the frame-start cycle bypasses staging.
  always_comb begin
    commit    = frame_start & (pending | Load);
    shadow_nx = shadow;
    if (commit) begin
      shadow_nx = Load ? Value : staging;
    end
  end

  // Digit select and leading-zero test for the slot being entered.
  always_comb begin
    digit_sel  = '0;
    lz         = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == idx_nx) begin
        digit_sel = shadow_nx[4*i +: 4];
      end
    end
    // Walk from the most significant digit down; upper_zero covers NDIG-1..i.
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (shadow_nx[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
      if ((LZ_SUPPRESS != 0) && upper_zero && (IW'(i) == idx_nx)) begin
        lz = 1'b1;
      end
    end
  end

  // Output values for the state being entered; Digit holds through gaps.
  always_comb begin
    digit_nx = Digit;
    en_nx    = 1'b0;
    anode_nx = '0;
    if (state_nx == SHOW) begin
      digit_nx = digit_sel;
      en_nx    = ~Blank & ~lz;
      anode_nx = en_nx ? (NDIG'(1) << idx_nx) : '0;
    end
  end

  // State register: FSM state, dwell/gap counter and digit index.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      state <= GAP;
      cnt   <= '0;
      idx   <= IDX_LAST;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Value staging and the registered display outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: staging and shadow are plain flop banks and take the reset, so
      // the first frame after reset always shows zeros and no stale value.
      staging    <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      Digit      <= '0;
      EnableSegs <= 1'b0;
      AnodeEn    <= '0;
      LoadAck    <= 1'b0;
    end else begin
      if (Load) begin
        staging <= Value;
      end
      shadow <= shadow_nx;
      if (commit) begin
        pending <= 1'b0;
      end else if (Load) begin
        pending <= 1'b1;
      end
      Digit      <= digit_nx;
      EnableSegs <= en_nx;
      AnodeEn    <= anode_nx;
      LoadAck    <= commit;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl
// Three instances share clock, reset and stimulus:
//   dut_a: NDIG=4 DWELL=4 GAP_CYC=1 LZ_SUPPRESS=1
//   dut_b: NDIG=4 DWELL=4 GAP_CYC=1 LZ_SUPPRESS=0
//   dut_c: NDIG=3 DWELL=1 GAP_CYC=2 LZ_SUPPRESS=1
// A reference model derives slot position from the cycle count since reset
// with plain arithmetic and tracks staged/displayed values per instance.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank;

  logic [3:0] digit_a, digit_b, digit_c;
  logic       en_a, en_b, en_c;
  logic [3:0] anode_a, anode_b;
  logic [2:0] anode_c;
  logic       ack_a, ack_b, ack_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NDIG(4), .DWELL(4), .GAP_CYC(1), .LZ_SUPPRESS(1)) dut_a (
    .Clk(clk), .Reset(rst), .Value(value), .Load(load), .Blank(blank),
    .Digit(digit_a), .EnableSegs(en_a), .AnodeEn(anode_a), .LoadAck(ack_a));

  seven_seg_scan_ctrl #(.NDIG(4), .DWELL(4), .GAP_CYC(1), .LZ_SUPPRESS(0)) dut_b (
    .Clk(clk), .Reset(rst), .Value(value), .Load(load), .Blank(blank),
    .Digit(digit_b), .EnableSegs(en_b), .AnodeEn(anode_b), .LoadAck(ack_b));

  seven_seg_scan_ctrl #(.NDIG(3), .DWELL(1), .GAP_CYC(2), .LZ_SUPPRESS(1)) dut_c (
    .Clk(clk), .Reset(rst), .Value(value[11:0]), .Load(load), .Blank(blank),
    .Digit(digit_c), .EnableSegs(en_c), .AnodeEn(anode_c), .LoadAck(ack_c));

  // ---------------- reference model ----------------
  int cfg_nd [3] = '{4, 4, 3};
  int cfg_dw [3] = '{4, 4, 1};
  int cfg_gp [3] = '{1, 1, 2};
  int cfg_lz [3] = '{1, 0, 1};

  int         m_n       [3];
  logic [3:0] m_shadow  [3][4];
  logic [3:0] m_staging [3][4];
  bit         m_pend    [3];
  logic [3:0] exp_digit [3];
  logic       exp_en    [3];
  logic [3:0] exp_anode [3];
  logic       exp_ack   [3];

  task automatic model_reset(input int c);
    m_n[c] = 0;
    m_pend[c] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      m_shadow[c][j]  = 4'h0;
      m_staging[c][j] = 4'h0;
    end
    exp_digit[c] = 4'h0;
    exp_en[c]    = 1'b0;
    exp_anode[c] = 4'h0;
    exp_ack[c]   = 1'b0;
  endtask

  task automatic model_step(input int c);
    int nd, dw, gp, slot_len, frame_len, q, idx;
    bit show, fs, zero, lz;
    nd = cfg_nd[c];
    dw = cfg_dw[c];
    gp = cfg_gp[c];
    slot_len  = dw + gp;
    frame_len = nd * slot_len;
    m_n[c] = m_n[c] + 1;
    show = 1'b0;
    fs   = 1'b0;
    idx  = 0;
    if (m_n[c] >= gp) begin
      q    = m_n[c] - gp;
      idx  = (q / slot_len) % nd;
      show = (q % slot_len) < dw;
      fs   = (q % frame_len) == 0;
    end
    exp_ack[c] = 1'b0;
    if (fs && (load || m_pend[c])) begin
      for (int j = 0; j < nd; j++)
        m_shadow[c][j] = load ? value[4*j +: 4] : m_staging[c][j];
      m_pend[c]  = 1'b0;
      exp_ack[c] = 1'b1;
    end else if (load) begin
      for (int j = 0; j < nd; j++) m_staging[c][j] = value[4*j +: 4];
      m_pend[c] = 1'b1;
    end
    if (show) begin
      zero = 1'b1;
      for (int j = idx; j < nd; j++)
        if (m_shadow[c][j] != 4'h0) zero = 1'b0;
      lz = (cfg_lz[c] != 0) && (idx != 0) && zero;
      exp_digit[c] = m_shadow[c][idx];
      exp_en[c]    = !blank && !lz;
      exp_anode[c] = exp_en[c] ? 4'(1 << idx) : 4'h0;
    end else begin
      exp_en[c]    = 1'b0;
      exp_anode[c] = 4'h0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int c = 0; c < 3; c++) begin
      if (rst) model_reset(c);
      else     model_step(c);
    end
  end

  // Advance to the negedge of a cycle that begins a frame on dut_a.
  task automatic align_frame();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!((m_n[0] >= 1) && ((m_n[0] - 1) % 20 == 0)) && guard < 100);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; load = 1'b0; blank = 1'b0; value = 16'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({digit_a, en_a, anode_a, ack_a} !== 10'h0) begin
      n_bad++;
      $display("FAIL reset_a got d=%h en=%b an=%b ack=%b want all zero", digit_a, en_a, anode_a, ack_a);
    end
    n_cmp++;
    if ({digit_b, en_b, anode_b, ack_b} !== 10'h0) begin
      n_bad++;
      $display("FAIL reset_b got d=%h en=%b an=%b ack=%b want all zero", digit_b, en_b, anode_b, ack_b);
    end
    n_cmp++;
    if ({digit_c, en_c, anode_c, ack_c} !== 9'h0) begin
      n_bad++;
      $display("FAIL reset_c got d=%h en=%b an=%b ack=%b want all zero", digit_c, en_c, anode_c, ack_c);
    end
  endtask

  // Load 1234 at cycle 0; check the whole scan pattern from the slot arithmetic.
  task automatic test_basic();
    int slot, r;
    logic [3:0] w_an, w_d;
    logic w_en, w_ack;
    rst = 1'b0; value = 16'h1234; load = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      slot  = (n - 1) / 5;
      r     = (n - 1) % 5;
      w_en  = (r < 4);
      w_an  = w_en ? 4'(1 << (slot % 4)) : 4'h0;
      w_d   = 4'(4 - (slot % 4));
      w_ack = (n == 1);
      n_cmp++;
      if ({digit_a, en_a, anode_a, ack_a} !== {w_d, w_en, w_an, w_ack}) begin
        n_bad++;
        $display("FAIL basic cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 n, digit_a, en_a, anode_a, ack_a, w_d, w_en, w_an, w_ack);
      end
      load = 1'b0;
    end
  endtask

  // 0070: upper two digits dark on dut_a, all four lit on dut_b.
  task automatic test_leading_zero();
    int lit_a [4];
    int lit_b [4];
    int acks, bad_digit;
    acks = 0; bad_digit = 0;
    for (int i = 0; i < 4; i++) begin lit_a[i] = 0; lit_b[i] = 0; end
    align_frame();
    value = 16'h0070; load = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      @(negedge clk);
      load = 1'b0;
      n_cmp++;
      if ({digit_a, en_a, anode_a, ack_a} !== {exp_digit[0], exp_en[0], exp_anode[0], exp_ack[0]}) begin
        n_bad++;
        $display("FAIL lz_model_a cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 m_n[0], digit_a, en_a, anode_a, ack_a, exp_digit[0], exp_en[0], exp_anode[0], exp_ack[0]);
      end
      n_cmp++;
      if ({digit_b, en_b, anode_b, ack_b} !== {exp_digit[1], exp_en[1], exp_anode[1], exp_ack[1]}) begin
        n_bad++;
        $display("FAIL lz_model_b cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 m_n[1], digit_b, en_b, anode_b, ack_b, exp_digit[1], exp_en[1], exp_anode[1], exp_ack[1]);
      end
      if (ack_a) acks++;
      if (k >= 20) begin
        for (int i = 0; i < 4; i++) begin
          if (anode_a == 4'(1 << i) && en_a) lit_a[i]++;
          if (anode_b == 4'(1 << i) && en_b) lit_b[i]++;
        end
        if (anode_a == 4'b0010 && digit_a != 4'h7) bad_digit++;
        if (anode_a == 4'b0001 && digit_a != 4'h0) bad_digit++;
      end
    end
    n_cmp++;
    if (lit_a[0] != 4 || lit_a[1] != 4 || lit_a[2] != 0 || lit_a[3] != 0) begin
      n_bad++;
      $display("FAIL lz_slots_a got lit=%0d,%0d,%0d,%0d want 4,4,0,0", lit_a[0], lit_a[1], lit_a[2], lit_a[3]);
    end
    n_cmp++;
    if (lit_b[0] != 4 || lit_b[1] != 4 || lit_b[2] != 4 || lit_b[3] != 4) begin
      n_bad++;
      $display("FAIL lz_off_slots_b got lit=%0d,%0d,%0d,%0d want 4,4,4,4", lit_b[0], lit_b[1], lit_b[2], lit_b[3]);
    end
    n_cmp++;
    if (bad_digit != 0 || acks != 1) begin
      n_bad++;
      $display("FAIL lz_digits got bad_digits=%0d acks=%0d want 0 and 1", bad_digit, acks);
    end
  endtask

  // Two loads inside one frame: old digits stay, next frame shows B, one ack.
  task automatic test_back_to_back();
    int acks, torn, b_lit;
    acks = 0; torn = 0; b_lit = 0;
    align_frame();
    for (int k = 1; k <= 39; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({digit_a, en_a, anode_a, ack_a} !== {exp_digit[0], exp_en[0], exp_anode[0], exp_ack[0]}) begin
        n_bad++;
        $display("FAIL b2b_model cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 m_n[0], digit_a, en_a, anode_a, ack_a, exp_digit[0], exp_en[0], exp_anode[0], exp_ack[0]);
      end
      if (ack_a) acks++;
      if (k < 20 && en_a && (digit_a == 4'hA || digit_a == 4'hB)) torn++;
      if (k >= 20 && en_a && anode_a != 4'h0 && digit_a == 4'hB) b_lit++;
      if (k == 5)      begin value = 16'hAAAA; load = 1'b1; end
      else if (k == 8) begin value = 16'hBBBB; load = 1'b1; end
      else             load = 1'b0;
    end
    n_cmp++;
    if (acks != 1 || torn != 0 || b_lit != 16) begin
      n_bad++;
      $display("FAIL b2b_summary got acks=%0d torn=%0d b_lit=%0d want 1, 0, 16", acks, torn, b_lit);
    end
  endtask

  // Blank on frame cycles 5..8 darkens 6..9; scan timing unchanged.
  task automatic test_blank();
    logic w_en;
    logic [3:0] w_an;
    align_frame();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      w_en = (k % 5 < 4) && !(k >= 6 && k <= 9);
      w_an = w_en ? 4'(1 << (k / 5)) : 4'h0;
      n_cmp++;
      if ({digit_a, en_a, anode_a} !== {4'hB, w_en, w_an}) begin
        n_bad++;
        $display("FAIL blank k=%0d got d=%h en=%b an=%b want d=b en=%b an=%b",
                 k, digit_a, en_a, anode_a, w_en, w_an);
      end
      blank = (k >= 5 && k <= 8);
    end
    blank = 1'b0;
  endtask

  // Reset during idx 2 with a pending load: async clear, no ack, zeros shown.
  task automatic test_reset_midframe();
    int acks;
    acks = 0;
    align_frame();
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) begin value = 16'h5555; load = 1'b1; end
      else load = 1'b0;
    end
    n_cmp++;
    if (anode_a !== 4'b0100 || digit_a !== 4'hB) begin
      n_bad++;
      $display("FAIL pre_reset_slot got an=%b d=%h want an=0100 d=b", anode_a, digit_a);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({digit_a, en_a, anode_a, ack_a} !== 10'h0) begin
      n_bad++;
      $display("FAIL async_reset got d=%h en=%b an=%b ack=%b want all zero", digit_a, en_a, anode_a, ack_a);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({digit_a, en_a, anode_a, ack_a} !== {exp_digit[0], exp_en[0], exp_anode[0], exp_ack[0]}) begin
        n_bad++;
        $display("FAIL post_reset_model cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 n, digit_a, en_a, anode_a, ack_a, exp_digit[0], exp_en[0], exp_anode[0], exp_ack[0]);
      end
      if (ack_a) acks++;
      if (n == 1) begin
        n_cmp++;
        if ({digit_a, en_a, anode_a} !== {4'h0, 1'b1, 4'b0001}) begin
          n_bad++;
          $display("FAIL post_reset_first got d=%h en=%b an=%b want d=0 en=1 an=0001", digit_a, en_a, anode_a);
        end
      end
    end
    n_cmp++;
    if (acks != 0) begin
      n_bad++;
      $display("FAIL post_reset_ack got acks=%0d want 0", acks);
    end
  endtask

  // dut_c: idx runs 0,1,2,0 with a 9-cycle frame.
  task automatic test_odd_geometry();
    int q, idx;
    logic w_en, w_ack;
    logic [2:0] w_an;
    logic [3:0] w_d;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; value = 16'h0987; load = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      load = 1'b0;
      if (n < 2) begin
        w_en = 1'b0; w_an = 3'b000; w_d = 4'h0;
      end else begin
        q    = n - 2;
        idx  = (q / 3) % 3;
        w_en = (q % 3 == 0);
        w_an = w_en ? 3'(1 << idx) : 3'b000;
        w_d  = 4'(7 + idx);
      end
      w_ack = (n == 2);
      n_cmp++;
      if ({digit_c, en_c, anode_c, ack_c} !== {w_d, w_en, w_an, w_ack}) begin
        n_bad++;
        $display("FAIL odd_geom cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 n, digit_c, en_c, anode_c, ack_c, w_d, w_en, w_an, w_ack);
      end
    end
  endtask

  // Random loads, values and blanking against the model on all instances.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({digit_a, en_a, anode_a, ack_a} !== {exp_digit[0], exp_en[0], exp_anode[0], exp_ack[0]}) begin
        n_bad++;
        $display("FAIL rand_a cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 m_n[0], digit_a, en_a, anode_a, ack_a, exp_digit[0], exp_en[0], exp_anode[0], exp_ack[0]);
      end
      n_cmp++;
      if ({digit_b, en_b, anode_b, ack_b} !== {exp_digit[1], exp_en[1], exp_anode[1], exp_ack[1]}) begin
        n_bad++;
        $display("FAIL rand_b cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 m_n[1], digit_b, en_b, anode_b, ack_b, exp_digit[1], exp_en[1], exp_anode[1], exp_ack[1]);
      end
      n_cmp++;
      if ({digit_c, en_c, anode_c, ack_c} !== {exp_digit[2], exp_en[2], exp_anode[2][2:0], exp_ack[2]}) begin
        n_bad++;
        $display("FAIL rand_c cyc=%0d got d=%h en=%b an=%b ack=%b want d=%h en=%b an=%b ack=%b",
                 m_n[2], digit_c, en_c, anode_c, ack_c, exp_digit[2], exp_en[2], exp_anode[2][2:0], exp_ack[2]);
      end
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:12] = 4'h0;
      blank = ($urandom_range(0, 3) == 0);
    end
    load  = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_zero();
    test_back_to_back();
    test_blank();
    test_reset_midframe();
    test_odd_geometry();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
